// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer driven by an external baud tick
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // bit_idx only needs to reach DATA_BITS-1; stop_cnt only needs to reach 1.
  localparam int              IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = (STOP_BITS == 2);
  localparam logic            ODD       = (PARITY_ODD != 0);
  localparam logic            HAS_PAR   = (PARITY_EN != 0);

  // The state names the bit currently driven on the line.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  // The parity bit rides above the data word so it falls into bit 0 once the
  // data bits have been shifted out.
  logic [DATA_BITS:0]   shift_q, shift_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      shift_q  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-line logic; nothing moves without a tick except the
  // handshake in IDLE.
  always_comb begin
    state_n    = state;
    shift_n    = shift_q;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    tx_n       = tx_q;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (tx_valid) begin
          shift_n = {(^tx_data) ^ ODD, tx_data};
          state_n = S_SYNC;
        end
      end

      // A tick in the transfer cycle was seen while still in IDLE, so the
      // start bit always waits for a later tick.
      S_SYNC: begin
        if (baud_tick) begin
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          tx_n      = shift_q[0];
          shift_n   = shift_q >> 1;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx == LAST_IDX) begin
            if (HAS_PAR) begin
              tx_n    = shift_q[0];
              state_n = S_PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = S_STOP;
            end
          end else begin
            tx_n      = shift_q[0];
            shift_n   = shift_q >> 1;
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across several frame formats
module tb_uart_tx;

  localparam int NI = 5;

  // Instances: 0=8N1, 1=8E1, 2=8O1, 3=8N2, 4=5O2
  function automatic int cfg_db(input int k); return (k == 4) ? 5 : 8; endfunction
  function automatic int cfg_pe(input int k); return (k == 1 || k == 2 || k == 4) ? 1 : 0; endfunction
  function automatic int cfg_po(input int k); return (k == 2 || k == 4) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int k); return (k == 3 || k == 4) ? 2 : 1; endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic [8:0] din   [NI];
  logic       valid [NI];
  logic       ready [NI];
  logic       tx    [NI];
  logic       busy  [NI];
  logic       done  [NI];
  int         xfers [NI];
  int         div = 6;
  int         checks = 0;
  int         errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = cfg_db(g);
    uart_tx #(
      .DATA_BITS (DB),
      .PARITY_EN (cfg_pe(g)),
      .PARITY_ODD(cfg_po(g)),
      .STOP_BITS (cfg_sb(g))
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .baud_tick(baud_tick),
      .tx_data  (din[g][DB-1:0]),
      .tx_valid (valid[g]),
      .tx_ready (ready[g]),
      .tx       (tx[g]),
      .tx_busy  (busy[g]),
      .tx_done  (done[g])
    );
  end

  always #5 clk = ~clk;

  // One-clock tick every div clocks
  initial begin
    forever begin
      for (int i = 0; i < div - 1; i++) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  // Count accepted words per instance
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      if (reset && valid[k] && ready[k]) xfers[k] <= xfers[k] + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Sends one word on instance k and checks every clock of the frame
  // against the bit list built from the frame rules.
  task automatic send_frame(input int k, input logic [8:0] data, input bit keep,
                            input bit collide, input bit pulse,
                            output int waits, output logic par_seen, output int ticks);
    bit         bits[$];
    logic [8:0] d;
    int         db, n, cyc;
    bit         t;
    logic       cur;
    db = cfg_db(k);
    d  = data & 9'((1 << db) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(d[i]);
    if (cfg_pe(k) != 0) bits.push_back((^d) ^ (cfg_po(k) != 0));
    for (int i = 0; i < cfg_sb(k); i++) bits.push_back(1'b1);
    n        = bits.size();
    waits    = 0;
    par_seen = 1'bx;
    ticks    = 0;
    din[k]   = d;
    do begin
      @(negedge clk);
      waits++;
    end while (!(ready[k] && (!collide || baud_tick)) && waits < 1000);
    if (waits >= 1000) begin
      timeout($sformatf("ready[%0d]", k));
      return;
    end
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("sync_tx[%0d]", k), tx[k], 1'b1);
    chk($sformatf("sync_busy[%0d]", k), busy[k], 1'b1);
    chk($sformatf("sync_ready[%0d]", k), ready[k], 1'b0);
    chk($sformatf("sync_done[%0d]", k), done[k], 1'b0);
    if (!keep) valid[k] = 1'b0;
    din[k] = 9'($urandom);
    cur = 1'b1;
    for (int j = 0; j <= n; j++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        t = baud_tick;
        #1;
        cyc++;
        if (pulse) valid[k] = 1'b0;
        if (!t) chk($sformatf("hold[%0d] bit %0d", k, j), tx[k], cur);
      end while (!t && cyc < 1000);
      if (!t) begin
        timeout($sformatf("tick[%0d] bit %0d", k, j));
        return;
      end
      ticks++;
      if (j < n) begin
        chk($sformatf("bit[%0d] %0d", k, j), tx[k], bits[j]);
        chk($sformatf("busy[%0d] %0d", k, j), busy[k], 1'b1);
        chk($sformatf("done_early[%0d] %0d", k, j), done[k], 1'b0);
        cur = bits[j];
        if (cfg_pe(k) != 0 && j == db + 1) par_seen = tx[k];
        if (pulse && j == 2) valid[k] = 1'b1;
      end else begin
        chk($sformatf("done[%0d]", k), done[k], 1'b1);
        chk($sformatf("end_tx[%0d]", k), tx[k], 1'b1);
        chk($sformatf("end_ready[%0d]", k), ready[k], 1'b1);
      end
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      chk($sformatf("done_pulse[%0d]", k), done[k], 1'b0);
      chk($sformatf("idle_ready[%0d]", k), ready[k], 1'b1);
      chk($sformatf("idle_tx[%0d]", k), tx[k], 1'b1);
    end
  endtask

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       exp_par;
    int         exp_ticks;
    int         div;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   w, tk, base, cyc, cnt, k;
    logic ps;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      din[i]   = '0;
    end
    vecs[0] = '{0, 9'h0A5, 1'b0, 11, 104};
    vecs[1] = '{1, 9'h0A5, 1'b0, 12, 6};
    vecs[2] = '{2, 9'h0A5, 1'b1, 12, 6};
    vecs[3] = '{1, 9'h007, 1'b1, 12, 6};
    vecs[4] = '{2, 9'h007, 1'b0, 12, 6};
    vecs[5] = '{3, 9'h0FF, 1'b0, 12, 5};
    vecs[6] = '{4, 9'h013, 1'b0, 10, 4};

    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tx[%0d]", i), tx[i], 1'b1);
      chk($sformatf("rst_ready[%0d]", i), ready[i], 1'b1);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
      chk($sformatf("rst_done[%0d]", i), done[i], 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      div = vecs[i].div;
      send_frame(vecs[i].k, vecs[i].data, 1'b0, 1'b0, 1'b0, w, ps, tk);
      chk($sformatf("vec%0d ticks", i), tk, vecs[i].exp_ticks);
      if (cfg_pe(vecs[i].k) != 0) chk($sformatf("vec%0d parity", i), ps, vecs[i].exp_par);
    end

    // Reset during the data bits of 0x3C
    div = 6;
    din[0] = 9'h03C;
    @(negedge clk);
    valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 2000) begin
      @(posedge clk);
      if (baud_tick) cnt++;
      cyc++;
    end
    #1;
    chk("pre_rst_tx", tx[0], 1'b0);
    chk("pre_rst_busy", busy[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx[0], 1'b1);
    chk("mid_rst_ready", ready[0], 1'b1);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_done", done[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, w, ps, tk);
    chk("after_rst ticks", tk, 11);

    // Back-to-back with tx_valid held high
    base = xfers[0];
    send_frame(0, 9'h055, 1'b1, 1'b0, 1'b0, w, ps, tk);
    send_frame(0, 9'h0AA, 1'b0, 1'b0, 1'b0, w, ps, tk);
    chk("b2b waits", w, 1);
    chk("b2b frames", xfers[0] - base, 2);

    // Tick coincident with the transfer edge
    send_frame(1, 9'h0C3, 1'b0, 1'b1, 1'b0, w, ps, tk);
    chk("collide ticks", tk, 12);

    // tx_valid pulse while busy is ignored
    base = xfers[2];
    send_frame(2, 9'h05A, 1'b0, 1'b0, 1'b1, w, ps, tk);
    chk("busy_pulse frames", xfers[2] - base, 1);

    // Randomized frames against the frame model
    for (int r = 0; r < 40; r++) begin
      k   = int'($urandom_range(0, NI - 1));
      div = int'($urandom_range(2, 9));
      send_frame(k, 9'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, w, ps, tk);
      chk($sformatf("rand%0d ticks", r), tk, 2 + cfg_db(k) + cfg_pe(k) + cfg_sb(k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
